aes_inv_subbytes_ctrl: RTL and testbench



---
 rtl/aes_inv_subbytes_ctrl.sv | 95 +++++++++
 tb/tb_aes_inv_subbytes_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_subbytes_ctrl.sv
// InvSubBytes over a 128-bit AES state using one 32-bit inverse S-box lookup,
// time-multiplexed across four cycles with valid/ready handshakes on both sides.
module aes_inv_subbytes_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

    // Entry x lives at bits [2047 - 8*x -: 8].
    localparam logic [2047:0] InvSboxTbl = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return InvSboxTbl[2047 - 8 * int'(x) -: 8];
    endfunction

    state_e        state_q, state_d;
    logic [127:0]  st_q, st_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   sub_in, sub_out;

    always_comb begin
        sub_in = st_q[127 - 32 * int'(cnt_q) -: 32];
        for (int b = 0; b < 4; b++) begin
            sub_out[31 - 8 * b -: 8] = inv_sbox(sub_in[31 - 8 * b -: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    st_d    = in_block;
                    cnt_d   = 2'd0;
                    state_d = StSub;
                end
            end
            StSub: begin
                st_d[127 - 32 * int'(cnt_q) -: 32] = sub_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            st_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from registered state only.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_block = st_q;

endmodule

// File: tb/tb_aes_inv_subbytes_ctrl.sv
// Directed bench with a scoreboard; expected values derive from a forward S-box model.
module tb_aes_inv_subbytes_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    aes_inv_subbytes_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   fwd   [256];
    logic [7:0]   inv_m [256];
    logic [2047:0] fwd_tbl;

    logic [127:0] pend  [$];
    logic [127:0] sb    [$];
    logic [127:0] src_q [$];
    int           acc_q [$];
    logic [127:0] exp_blk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] b);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = inv_m[b[127 - 8 * k -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] b);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = fwd[b[127 - 8 * k -: 8]];
        return r;
    endfunction

    // Streams every block in pend with out_ready held high; scoreboard checks in order.
    task automatic run_stream(input int budget);
        int n = 0;
        out_ready = 1'b1;
        if (pend.size() > 0) begin
            in_valid = 1'b1;
            in_block = pend[0];
        end
        while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
            if (out_valid && out_ready) begin
                chk1("spurious_out", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp_blk = sb.pop_front();
                    chk("stream_out", out_block, exp_blk);
                    exp_blk = src_q.pop_front();
                    chk("fwd_roundtrip", model_fwd(out_block), exp_blk);
                end
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc);
                sb.push_back(model_inv(pend[0]));
                src_q.push_back(pend[0]);
                void'(pend.pop_front());
            end
            tick();
            n++;
            if (pend.size() > 0) begin
                in_valid = 1'b1;
                in_block = pend[0];
            end else begin
                in_valid = 1'b0;
            end
        end
        chk1("stream_timeout", n < budget, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk1(tag, out_valid, 1'b1);
    endtask

    initial begin
        fwd_tbl = {
            128'h637c777bf26b6fc53001672bfed7ab76,
            128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115,
            128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84,
            128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8,
            128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973,
            128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479,
            128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
            128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df,
            128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int i = 0; i < 256; i++) begin
            fwd[i] = fwd_tbl[2047 - 8 * i -: 8];
            inv_m[fwd[i]] = 8'(i);
        end

        // Reset with in_valid high: reset must win.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_block  = 128'h0123456789abcdef0123456789abcdef;
        out_ready = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_out_block", out_block, 128'h0);

        // First block with exact latency check.
        in_valid = 1'b1;
        in_block = 128'h63636363_7c7c7c7c_00000000_ffffffff;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk1("lat_out_valid_low", out_valid, 1'b0);
            chk1("lat_busy", busy, 1'b1);
        end
        tick();
        chk1("lat_out_valid_high", out_valid, 1'b1);
        chk1("lat_busy_done", busy, 1'b1);
        chk("vec1_const", out_block, 128'h00000000_01010101_52525252_7d7d7d7d);
        chk("vec1_model", out_block, model_inv(128'h63636363_7c7c7c7c_00000000_ffffffff));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("vec1_idle_ready", in_ready, 1'b1);
        chk1("vec1_idle_busy", busy, 1'b0);

        // Mixed-byte block.
        pend.push_back(128'h00011652_63ff7c00_16165252_01010101);
        run_stream(40);
        chk("mixed_const", out_block, 128'h5209ff48_007d0152_ffff4848_09090909);

        // Backpressure: DONE held for 10 cycles while a new in_valid is offered.
        in_valid = 1'b1;
        in_block = 128'h00112233_44556677_8899aabb_ccddeeff;
        exp_blk  = model_inv(in_block);
        tick();
        in_valid = 1'b0;
        wait_out_valid("bp_reach_done");
        in_valid = 1'b1;
        in_block = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 10; k++) begin
            tick();
            chk1("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_block", out_block, exp_blk);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("bp_idle_ready", in_ready, 1'b1);
        chk1("bp_idle_out_valid", out_valid, 1'b0);
        chk("bp_no_capture", out_block, exp_blk);

        // Back-to-back with in_valid and out_ready held high.
        acc_q.delete();
        pend.push_back(128'hdeadbeef_cafef00d_01234567_89abcdef);
        pend.push_back(128'hfedcba98_76543210_0f1e2d3c_4b5a6978);
        run_stream(60);
        chk1("b2b_two_accepts", acc_q.size() == 2, 1'b1);
        if (acc_q.size() == 2) chk("b2b_interval", 128'(acc_q[1] - acc_q[0]), 128'd6);

        // Reset during the second SUB cycle aborts the block.
        in_valid = 1'b1;
        in_block = 128'h11111111_22222222_33333333_44444444;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk("abort_out_block", out_block, 128'h0);
        pend.push_back(128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c);
        run_stream(40);

        // 64 blocks: each byte lane of the 32-bit lookup sees all 256 values.
        for (int b = 0; b < 64; b++) begin
            logic [127:0] blk;
            for (int w = 0; w < 4; w++) begin
                for (int j = 0; j < 4; j++) begin
                    blk[127 - 32 * w - 8 * j -: 8] = 8'((b * 4 + w + 67 * j) & 255);
                end
            end
            pend.push_back(blk);
        end
        run_stream(64 * 8 + 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
